// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar drain path and the scheduler tree:
// drain FSM state encoding and the power-of-two helper used to size
// the source count from the source-id width.
package xbar_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } xbar_state_e;

    // Number of sources addressable by an id field of width w.
    function automatic int pow2(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/xbar_src_mux.sv
// Source selector for the drain path: picks the data slice and valid bit
// of the latched source and decodes the one-hot per-source ready.
// The select depends only on the latched id, never on the scheduler.
module xbar_src_mux
    import xbar_pkg::*;
#(
    parameter int ID_WIDTH   = 5,
    parameter int DATA_WIDTH = 32,
    localparam int NUM       = pow2(ID_WIDTH)
) (
    input  logic                      en,
    input  logic [ID_WIDTH-1:0]       sel_id,
    input  logic [NUM*DATA_WIDTH-1:0] in_data,
    input  logic [NUM-1:0]            in_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     sel_data,
    output logic                      sel_valid,
    output logic [NUM-1:0]            in_ready
);

    // Route the selected source to the output; ready goes back only to it.
    always_comb begin
        sel_data  = in_data[sel_id*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = en && in_valid[sel_id];
        in_ready  = '0;
        for (int k = 0; k < NUM; k++) begin
            in_ready[k] = en && out_ready && (sel_id == ID_WIDTH'(k));
        end
    end

endmodule

// File: rtl/xbar_drain.sv
// Crossbar drain engine: accepts the winner of the max-length scheduler
// tree while idle, then drains that many beats from the winning source
// before returning to idle for the next arbitration slot.
// Optional feature: define XBAR_DRAIN_BURST_CAP_EN to cap each granted
// burst at MAX_BURST beats.
module xbar_drain
    import xbar_pkg::*;
#(
    parameter int LEN_WIDTH  = 10,
    parameter int ID_WIDTH   = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    localparam int NUM       = pow2(ID_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LEN_WIDTH-1:0]      sched_len,
    input  logic [ID_WIDTH-1:0]       sched_id,
    input  logic [NUM*DATA_WIDTH-1:0] in_data,
    input  logic [NUM-1:0]            in_valid,
    output logic [NUM-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [ID_WIDTH-1:0]       out_id,
    output logic                      grant_valid,
    output logic [LEN_WIDTH-1:0]      grant_len,
    output logic                      busy
);

    xbar_state_e          state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]  cur_id_q, cur_id_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [LEN_WIDTH-1:0] grant_len_q, grant_len_d;
    logic [LEN_WIDTH-1:0] granted_len;
    logic                 draining;
    logic                 sel_valid;
    logic                 xfer;

    assign draining = (state_q == DRAIN);

`ifdef XBAR_DRAIN_BURST_CAP_EN
    // Clamp the scheduler's queue length to the burst cap.
    always_comb begin
        granted_len = sched_len;
        if (32'(sched_len) > 32'(MAX_BURST)) begin
            granted_len = LEN_WIDTH'(MAX_BURST);
        end
    end
`else
    // Without the cap the whole queue length is granted.
    always_comb begin
        granted_len = sched_len;
    end

    logic unused_max_burst;
    assign unused_max_burst = (MAX_BURST != 0);
`endif

    xbar_src_mux #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_src_mux (
        .en        (draining),
        .sel_id    (cur_id_q),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .sel_data  (out_data),
        .sel_valid (sel_valid),
        .in_ready  (in_ready)
    );

    assign xfer = sel_valid && out_ready;

    // Next-state: grant from idle, count transfers down while draining.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cur_id_d      = cur_id_q;
        grant_valid_d = 1'b0;
        grant_len_d   = grant_len_q;
        unique case (state_q)
            IDLE: begin
                if (sched_len != '0) begin
                    cur_id_d      = sched_id;
                    cnt_d         = granted_len;
                    grant_valid_d = 1'b1;
                    grant_len_d   = granted_len;
                    state_d       = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state with synchronous reset; reset abandons any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cur_id_q      <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_id_q      <= cur_id_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    // Granted length is only qualified by grant_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        grant_len_q <= grant_len_d;
    end

    assign out_valid   = sel_valid;
    assign out_last    = draining && (cnt_q == LEN_WIDTH'(1));
    assign out_id      = cur_id_q;
    assign grant_valid = grant_valid_q;
    assign grant_len   = grant_len_q;
    assign busy        = draining;

endmodule

// File: tb/tb_xbar_drain.sv
// Directed + randomized bench for xbar_drain. Each source presents a
// numbered word stream; a burst is expected to consume exactly the
// granted number of words of the granted source, in order, with the
// last-beat flag on the final one only.
module tb_xbar_drain;

    localparam int LEN_W     = 10;
    localparam int ID_W      = 5;
    localparam int DW        = 32;
    localparam int MAX_BURST = 16;
    localparam int NUM       = 1 << ID_W;

    logic                clk = 1'b0;
    logic                rst;
    logic [LEN_W-1:0]    sched_len;
    logic [ID_W-1:0]     sched_id;
    logic [NUM*DW-1:0]   in_data;
    logic [NUM-1:0]      in_valid;
    logic [NUM-1:0]      in_ready;
    logic [DW-1:0]       out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [ID_W-1:0]     out_id;
    logic                grant_valid;
    logic [LEN_W-1:0]    grant_len;
    logic                busy;

    int errors = 0;
    int checks = 0;
    int src_pos [NUM];
    logic [DW-1:0] salt [NUM];

    xbar_drain #(
        .LEN_WIDTH  (LEN_W),
        .ID_WIDTH   (ID_W),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sched_len   (sched_len),
        .sched_id    (sched_id),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_id      (out_id),
        .grant_valid (grant_valid),
        .grant_len   (grant_len),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word number pos of source id's stream.
    function automatic logic [DW-1:0] word(input int id, input int pos);
        return (DW'(id) << 24) ^ DW'(pos) ^ salt[id];
    endfunction

    // Beats a request of len should be granted.
    function automatic int exp_grant(input int len);
`ifdef XBAR_DRAIN_BURST_CAP_EN
        return (len > MAX_BURST) ? MAX_BURST : len;
`else
        return len;
`endif
    endfunction

    // Random traffic on every source, then the drained source's stream word.
    task automatic drive_sources(input int id, input bit vld);
        in_valid = NUM'($urandom);
        for (int k = 0; k < NUM; k++) in_data[k*DW +: DW] = $urandom;
        in_valid[id] = vld;
        in_data[id*DW +: DW] = word(id, src_pos[id]);
    endtask

    // rmode: 0 always ready, 1 toggling 1,0,1,0.., 2 random
    // vmode: 0 source always valid, 1 gapped
    // abort_after: if nonzero, reset after that many transfers
    task automatic burst(input int len, input int id, input int rmode,
                         input int vmode, input int abort_after);
        int exp_len;
        int n;
        int cyc;
        int budget;
        bit rdy;
        bit vld;
        logic [63:0] one;
        one     = 64'd1;
        exp_len = exp_grant(len);
        budget  = exp_len * 20 + 50;

        @(negedge clk);
        sched_len = LEN_W'(len);
        sched_id  = ID_W'(id);
        out_ready = 1'($urandom);
        drive_sources(id, 1'b1);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_out_last", out_last, 0);

        @(posedge clk);
        #1;
        chk("grant_valid", grant_valid, 1);
        chk("grant_len", grant_len, exp_len);
        chk("grant_busy", busy, 1);

        n = 0;
        cyc = 0;
        while (n < exp_len && cyc < budget) begin
            @(negedge clk);
            sched_len = LEN_W'($urandom);
            sched_id  = ID_W'($urandom);
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom);
            vld = (vmode == 0) ? 1'b1 : ($urandom % 3 != 0);
            out_ready = rdy;
            drive_sources(id, vld);
            #1;
            chk("drain_grant_pulse", grant_valid, (cyc == 0));
            chk("drain_busy", busy, 1);
            chk("drain_out_id", out_id, id);
            chk("drain_out_valid", out_valid, vld);
            chk("drain_in_ready", in_ready, rdy ? (one << id) : 64'd0);
            chk("drain_out_last", out_last, (n == exp_len - 1));
            if (vld && rdy) begin
                chk("drain_out_data", out_data, word(id, src_pos[id]));
                src_pos[id]++;
                n++;
            end
            cyc++;
            if (abort_after != 0 && n == abort_after) break;
        end

        if (abort_after != 0 && n == abort_after) begin
            @(negedge clk);
            rst = 1'b1;
            sched_len = LEN_W'(5);
            out_ready = 1'b1;
            in_valid = '1;
            @(posedge clk);
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_grant_valid", grant_valid, 0);
            @(posedge clk);
            #1;
            chk("rst_hold_grant", grant_valid, 0);
            chk("rst_hold_busy", busy, 0);
            @(negedge clk);
            rst = 1'b0;
            sched_len = '0;
            return;
        end

        chk("burst_beats", n, exp_len);
        @(negedge clk);
        sched_len = '0;
        out_ready = 1'($urandom);
        drive_sources(id, 1'b1);
        #1;
        chk("post_busy", busy, 0);
        chk("post_out_valid", out_valid, 0);
        chk("post_out_last", out_last, 0);
        chk("post_in_ready", in_ready, 0);
        chk("post_grant_valid", grant_valid, 0);
    endtask

    initial begin
        for (int k = 0; k < NUM; k++) begin
            src_pos[k] = 0;
            salt[k] = $urandom;
        end
        rst = 1'b1;
        sched_len = '0;
        sched_id = '0;
        out_ready = 1'b0;
        in_valid = '0;
        in_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_grant_valid", grant_valid, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_id", out_id, 0);
        @(negedge clk);
        rst = 1'b0;

        // Zero length held: never grants
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sched_len = '0;
            sched_id = ID_W'($urandom);
            out_ready = 1'($urandom);
            drive_sources(0, 1'b1);
            #1;
            chk("zero_grant_valid", grant_valid, 0);
            chk("zero_busy", busy, 0);
            chk("zero_in_ready", in_ready, 0);
            chk("zero_out_valid", out_valid, 0);
        end

        // Basic three-beat burst from source 5
        burst(3, 5, 0, 0, 0);
        // Four beats with toggling ready and gapped valid
        burst(4, 9, 1, 1, 0);
        // Reset after beat 2 of 5, then a fresh grant
        burst(5, 12, 0, 0, 2);
        burst(3, 12, 0, 0, 0);
        // Long request (capped or not depending on build)
        burst(40, 3, 0, 0, 0);
        // Boundaries: exactly the cap, one beat, cap+1, widest length
        burst(16, 31, 2, 1, 0);
        burst(1, 0, 0, 0, 0);
        burst(1, 31, 2, 1, 0);
        burst(17, 7, 2, 0, 0);
        burst((1 << LEN_W) - 1, 20, 0, 0, 0);
        // Randomized bursts
        for (int i = 0; i < 8; i++) begin
            burst($urandom_range(24, 1), $urandom_range(NUM - 1, 0),
                  $urandom_range(2, 0), $urandom_range(1, 0), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xbar_drain.md
XBAR_DRAIN -- requirements
Module: xbar_drain

Interface
REQ-001 Parameter LEN_WIDTH, default 10, sets the width of a queue-length / burst-length field.
REQ-002 Parameter ID_WIDTH, default 5, sets the source-id width; NUM = 2**ID_WIDTH sources.
REQ-003 Parameter DATA_WIDTH, default 32, sets the beat width.
REQ-004 Parameter MAX_BURST, default 16, sets the burst cap; it is used only under XBAR_DRAIN_BURST_CAP_EN.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 Port rst, input, 1 bit: reset; synchronous and active-high.
REQ-007 Port sched_len, input, LEN_WIDTH bits: the winning queue length from the max-length scheduler tree.
REQ-008 Port sched_id, input, ID_WIDTH bits: the winning source id from the scheduler tree.
REQ-009 Port in_data, input, NUM*DATA_WIDTH bits: source beats; source k occupies [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port in_valid, input, NUM bits: per-source beat valid.
REQ-011 Port in_ready, output, NUM bits: per-source ready; at most one bit is high.
REQ-012 Port out_data, output, DATA_WIDTH bits: the drained beat.
REQ-013 Port out_valid / out_ready, output / input, 1 bit each: valid/ready handshake on the output.
REQ-014 Port out_last, output, 1 bit: marks the final beat of a burst.
REQ-015 Port out_id, output, ID_WIDTH bits: the source id of the current burst.
REQ-016 Port grant_valid, output, 1 bit: single-cycle pulse when a burst is granted.
REQ-017 Port grant_len, output, LEN_WIDTH bits: granted beat count, meaningful while grant_valid is high.
REQ-018 Port busy, output, 1 bit: high while in DRAIN.

Function
REQ-019 The FSM SHALL have exactly two states, IDLE and DRAIN.
REQ-020 In IDLE with sched_len != 0, the block SHALL latch sched_id into cur_id, latch the granted length into cnt, pulse grant_valid and drive grant_len with that length, then enter DRAIN on the next cycle.
REQ-021 In IDLE with sched_len == 0, the block SHALL stay in IDLE with grant_valid low.
REQ-022 In DRAIN: out_valid = in_valid[cur_id]; out_data = the cur_id slice of in_data; in_ready[cur_id] = out_ready; all other in_ready bits = 0; out_id = cur_id.
REQ-023 A transfer is out_valid && out_ready; each transfer SHALL decrement cnt by 1.
REQ-024 out_last SHALL be high exactly when in DRAIN and cnt == 1.
REQ-025 A transfer with cnt == 1 SHALL return the FSM to IDLE.
REQ-026 sched_len and sched_id SHALL be ignored while in DRAIN.
REQ-027 Bursts SHALL be separated by at least one IDLE cycle (re-arbitration slot).
REQ-028 In IDLE, out_valid, out_last, and all in_ready bits SHALL be 0.
REQ-029 A source deasserting in_valid mid-burst SHALL stall the burst without changing cnt; there is no timeout.
REQ-030 The combinational path from sched_* to the out_* datapath SHALL not exist; the output select depends only on cur_id.

Reset
REQ-031 rst SHALL force IDLE, cnt = 0, cur_id = 0, grant_valid = 0, and busy = 0; out_valid, out_last, and in_ready then follow REQ-028.
REQ-032 rst asserted mid-burst SHALL abandon the burst with no out_last; the first grant after release SHALL be at the earliest one cycle after rst falls.

Configuration
REQ-033 Macro XBAR_DRAIN_BURST_CAP_EN defined: granted length = min(sched_len, MAX_BURST), so grant_len reports the capped value.
REQ-034 Macro XBAR_DRAIN_BURST_CAP_EN undefined: granted length = sched_len, and MAX_BURST is unused.

Structure
REQ-035 Package xbar_pkg SHALL hold the IDLE/DRAIN state encoding and the power-of-two helper function used to derive NUM, shared with the scheduler tree.
REQ-036 One sub-module, xbar_src_mux, SHALL select the cur_id data slice and valid bit and decode the one-hot in_ready; the FSM and counter stay in xbar_drain.

Verification
REQ-037 Test: sched_len=3, sched_id=5, out_ready=1, in_valid[5]=1 -> grant_valid pulse with grant_len=3, then 3 beats with out_id=5, out_last on beat 3, then IDLE.
REQ-038 Test: sched_len=0 held for 10 cycles -> no grant_valid, busy=0, in_ready=0 throughout.
REQ-039 Test: sched_len=4, out_ready toggled 1,0,1,0 and in_valid gapped -> exactly 4 transfers, data order preserved, no duplicated beats.
REQ-040 Test: rst pulsed after beat 2 of a 5-beat burst -> next cycle busy=0, in_ready=0, no out_last; a new grant follows after release.
REQ-041 Test: with XBAR_DRAIN_BURST_CAP_EN and MAX_BURST=16, sched_len=40 -> grant_len=16 and out_last on beat 16; without the macro -> grant_len=40 and 40 beats.
REQ-042 Test: sched_id changed during DRAIN -> out_id and in_ready stay on the latched id until out_last.
